// File: rtl/layer_mem_responder_pkg.sv
// Shared constants for the layer memory responder: widths, bank select codes,
// bank depths, the dump FSM state type and bank decode helpers.
package layer_mem_responder_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int ADDR_WIDTH = 12;
  localparam int NUM_BANKS  = 5;

  localparam logic [2:0] SEL_L0_MEM0 = 3'b001;
  localparam logic [2:0] SEL_L0_MEM1 = 3'b010;
  localparam logic [2:0] SEL_L1_MEM0 = 3'b011;
  localparam logic [2:0] SEL_L1_MEM1 = 3'b100;
  localparam logic [2:0] SEL_L2_MEM  = 3'b101;

  localparam int DEPTH_L0_MEM0 = 4096;
  localparam int DEPTH_L0_MEM1 = 4096;
  localparam int DEPTH_L1_MEM0 = 1024;
  localparam int DEPTH_L1_MEM1 = 1024;
  localparam int DEPTH_L2_MEM  = 2048;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DUMP_PRIME  = 2'd1,
    DUMP_STREAM = 2'd2
  } dump_state_e;

  // Depth of the bank addressed by a select code; 0 marks an illegal code.
  function automatic int unsigned bank_depth(input logic [2:0] sel);
    case (sel)
      SEL_L0_MEM0: return DEPTH_L0_MEM0;
      SEL_L0_MEM1: return DEPTH_L0_MEM1;
      SEL_L1_MEM0: return DEPTH_L1_MEM0;
      SEL_L1_MEM1: return DEPTH_L1_MEM1;
      SEL_L2_MEM:  return DEPTH_L2_MEM;
      default:     return 0;
    endcase
  endfunction

  function automatic logic sel_legal(input logic [2:0] sel);
    return bank_depth(sel) != 0;
  endfunction

endpackage

// File: rtl/layer_mem_responder_mem_bank.sv
// Single-port-write / single-port-read storage bank with a registered read.
// A read and write to the same word on one edge returns the old contents.
module mem_bank #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_mem_responder.sv
// Host-facing responder for five layer memory banks: validated reads/writes,
// a sticky protocol error flag, a saturating write counter, and a dump engine
// that streams a whole bank out one word per cycle.
module layer_mem_responder #(
  parameter int DATA_WIDTH = layer_mem_responder_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = layer_mem_responder_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            csel,
  input  logic                  cwr,
  input  logic [ADDR_WIDTH-1:0] caddr_wr,
  input  logic [DATA_WIDTH-1:0] cdata_wr,
  input  logic                  crd,
  input  logic [ADDR_WIDTH-1:0] caddr_rd,
  output logic [DATA_WIDTH-1:0] cdata_rd,
  input  logic                  dump_req,
  input  logic [2:0]            dump_sel,
  output logic                  dump_busy,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  err,
  output logic [12:0]           wr_count
);
  import layer_mem_responder_pkg::*;

  localparam logic [12:0] WR_COUNT_MAX = 13'd8191;

  dump_state_e           state, state_nxt;
  logic                  busy, wr_ok, rd_ok, rd_ill, dump_ok, dump_issue, req_err;
  logic [2:0]            dump_bank;
  logic [ADDR_WIDTH-1:0] iss_addr, last_addr, bank_raddr;
  logic                  iss_done;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic [2:0]            rd_bank_p0;
  logic                  rd_vld_p0, rd_ill_p0, dvld_p0, dlast_p0;
  logic [ADDR_WIDTH-1:0] daddr_p0;

  function automatic logic addr_ok(input logic [2:0] sel, input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < (ADDR_WIDTH+1)'(bank_depth(sel));
  endfunction

  // Request qualification: while a dump runs every host request is refused.
  always_comb begin
    busy       = (state != IDLE);
    wr_ok      = !busy && cwr && sel_legal(csel) && addr_ok(csel, caddr_wr);
    rd_ok      = !busy && crd && sel_legal(csel) && addr_ok(csel, caddr_rd);
    rd_ill     = !busy && crd && !rd_ok;
    dump_ok    = !busy && dump_req && sel_legal(dump_sel) && !cwr && !crd;
    req_err    = busy ? (cwr || crd || dump_req)
                      : ((cwr && !wr_ok) || rd_ill || (dump_req && !dump_ok));
    dump_issue = (state == DUMP_PRIME) || ((state == DUMP_STREAM) && !iss_done);
    last_addr  = ADDR_WIDTH'(bank_depth(dump_bank) - 1);
    bank_raddr = dump_issue ? iss_addr : caddr_rd;
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    localparam logic [2:0] SEL   = 3'(g + 1);
    localparam int         DEPTH = int'(bank_depth(SEL));
    localparam int         IDX_W = $clog2(DEPTH);
    logic we, re;
    assign we = wr_ok && (csel == SEL);
    assign re = (rd_ok && (csel == SEL)) || (dump_issue && (dump_bank == SEL));
    mem_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk   (clk),
      .we    (we),
      .waddr (caddr_wr[IDX_W-1:0]),
      .wdata (cdata_wr),
      .re    (re),
      .raddr (bank_raddr[IDX_W-1:0]),
      .rdata (bank_rdata[g])
    );
  end

  // Select the bank whose registered read is being consumed this cycle.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (rd_bank_p0 == 3'(i + 1)) rdata_sel = bank_rdata[i];
  end

  // Dump FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dump FSM next state: stay in STREAM until the last word has been presented.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (dump_ok) state_nxt = DUMP_PRIME;
      DUMP_PRIME:  state_nxt = DUMP_STREAM;
      DUMP_STREAM: if (dump_last) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Dump address generator: latches the bank and walks 0..depth-1 once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dump_bank <= '0;
      iss_addr  <= '0;
      iss_done  <= 1'b0;
    end else if (dump_ok) begin
      dump_bank <= dump_sel;
      iss_addr  <= '0;
      iss_done  <= 1'b0;
    end else if (dump_issue) begin
      iss_addr <= iss_addr + ADDR_WIDTH'(1);
      if (iss_addr == last_addr) iss_done <= 1'b1;
    end
  end

  // p0: bank read in flight; remember who asked and what it means.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p0  <= 1'b0;
      rd_ill_p0  <= 1'b0;
      dvld_p0    <= 1'b0;
      dlast_p0   <= 1'b0;
      daddr_p0   <= '0;
      rd_bank_p0 <= '0;
    end else begin
      rd_vld_p0 <= rd_ok;
      rd_ill_p0 <= rd_ill;
      dvld_p0   <= dump_issue;
      dlast_p0  <= dump_issue && (iss_addr == last_addr);
      daddr_p0  <= iss_addr;
      if (rd_ok)           rd_bank_p0 <= csel;
      else if (dump_issue) rd_bank_p0 <= dump_bank;
    end
  end

  // p1: registered host read data and dump stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdata_rd   <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      if (rd_vld_p0)      cdata_rd <= rdata_sel;
      else if (rd_ill_p0) cdata_rd <= '0;
      dump_valid <= dvld_p0;
      dump_last  <= dvld_p0 && dlast_p0;
      if (dvld_p0) begin
        dump_addr <= daddr_p0;
        dump_data <= rdata_sel;
      end
    end
  end

  // Sticky error flag and saturating accepted-write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      if (req_err) err <= 1'b1;
      if (wr_ok && (wr_count != WR_COUNT_MAX)) wr_count <= wr_count + 13'd1;
    end
  end

  assign dump_busy = busy;

endmodule
